// File: rtl/display_update_ctrl_pkg.sv
// display_update_ctrl_pkg
//   Shared definitions for the display update controller: FSM state
//   encoding, BCD digit width and the largest decimal value that fits in a
//   given number of digits.
package display_update_ctrl_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // 10^digits - 1, the largest value the display can show unsaturated.
    function automatic logic [31:0] max_dec(input int digits);
        logic [31:0] m;
        m = 32'd1;
        for (int i = 0; i < digits; i++) m = m * 32'd10;
        return m - 32'd1;
    endfunction

endpackage

// File: rtl/display_update_ctrl_bcd_add3.sv
// bcd_add3
//   Combinational shift-add-3 correction for one BCD digit: a digit of 5 or
//   more gets +3 so that the following left shift carries into the next digit.
//   Ports:
//     i_Digit  in   4   BCD digit before correction
//     o_Digit  out  4   corrected digit
module bcd_add3 (
    input  logic [3:0] i_Digit,
    output logic [3:0] o_Digit
);
    assign o_Digit = (i_Digit >= 4'd5) ? i_Digit + 4'd3 : i_Digit;
endmodule

// File: rtl/display_update_ctrl.sv
// display_update_ctrl
//   Accepts a binary measurement over valid/ready, converts it to BCD one bit
//   per clock (shift-add-3), then latches digits, leading-zero blank mask and
//   overflow flag for the 7-seg decoders. A hold period after each update
//   rate-limits the display.
//   Ports:
//     i_Clk     in   1         system clock
//     i_Rst     in   1         synchronous reset, active-high
//     i_Num     in   NUM_W     binary value to display
//     i_Valid   in   1         i_Num valid
//     o_Ready   out  1         controller can accept (transfer on i_Valid && o_Ready)
//     o_Digits  out  4*DIGITS  latched BCD, digit0 = units in [3:0]
//     o_Blank   out  DIGITS    1 = leading-zero digit; bit0 always 0
//     o_Ovf     out  1         latched value exceeded 10^DIGITS-1
//     o_Done    out  1         one-cycle pulse when latched outputs change
module display_update_ctrl
    import display_update_ctrl_pkg::*;
#(
    parameter int NUM_W       = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_CYC = 1000
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [NUM_W-1:0]          i_Num,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    output logic [BCD_W*DIGITS-1:0]   o_Digits,
    output logic [DIGITS-1:0]         o_Blank,
    output logic                      o_Ovf,
    output logic                      o_Done
);
    localparam int          BCD_TOT = BCD_W * DIGITS;
    localparam int          CNT_W   = $clog2(NUM_W + 1);
    localparam int          HOLD_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC + 1) : 1;
    localparam logic [31:0] MAX_DEC = max_dec(DIGITS);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t              r_State;
    logic                r_Ready;
    logic [NUM_W-1:0]    r_Bin;
    logic [BCD_TOT-1:0]  r_Bcd;
    logic [CNT_W-1:0]    r_Cnt;
    logic [HOLD_W-1:0]   r_Hold;
    logic                r_OvfPend;
    logic [BCD_TOT-1:0]  r_Digits;
    logic [DIGITS-1:0]   r_Blank;
    logic                r_Ovf;
    logic                r_Done;

    logic [BCD_TOT-1:0]  w_Add3;
    logic [DIGITS-1:0]   w_Blank;
    logic                w_Zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_Digit (r_Bcd[BCD_W*g +: BCD_W]),
            .o_Digit (w_Add3[BCD_W*g +: BCD_W])
        );
    end

    // Digit k is blank when it and every more significant digit are zero.
    always_comb begin
        w_Blank = '0;
        w_Zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_Zero     = w_Zero && (r_Bcd[BCD_W*k +: BCD_W] == 4'd0);
            w_Blank[k] = w_Zero;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State   <= ST_IDLE;
            r_Ready   <= 1'b0;
            r_Bin     <= '0;
            r_Bcd     <= '0;
            r_Cnt     <= '0;
            r_Hold    <= '0;
            r_OvfPend <= 1'b0;
            r_Digits  <= '0;
            r_Blank   <= BLANK_RST;
            r_Ovf     <= 1'b0;
            r_Done    <= 1'b0;
        end else begin
            r_Done <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (i_Valid && r_Ready) begin
                        r_Bin     <= i_Num;
                        r_Bcd     <= '0;
                        r_Cnt     <= CNT_W'(NUM_W);
                        r_OvfPend <= (32'(i_Num) > MAX_DEC);
                        r_Ready   <= 1'b0;
                        r_State   <= ST_SHIFT;
                    end else begin
                        r_Ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Correct then shift; the top BCD bit falls off (value saturates via ovf).
                    {r_Bcd, r_Bin} <= {w_Add3[BCD_TOT-2:0], r_Bin, 1'b0};
                    r_Cnt          <= r_Cnt - CNT_W'(1);
                    if (r_Cnt == CNT_W'(1)) r_State <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_Digits <= r_OvfPend ? {DIGITS{4'h9}} : r_Bcd;
                    r_Blank  <= r_OvfPend ? '0 : w_Blank;
                    r_Ovf    <= r_OvfPend;
                    r_Done   <= 1'b1;
                    if (REFRESH_CYC == 0) begin
                        r_Ready <= 1'b1;
                        r_State <= ST_IDLE;
                    end else begin
                        r_Hold  <= HOLD_W'(REFRESH_CYC);
                        r_State <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Ready rises on the last hold cycle so accepts are exactly
                    // NUM_W+2+REFRESH_CYC clocks apart.
                    if (r_Hold <= HOLD_W'(1)) begin
                        r_Ready <= 1'b1;
                        r_State <= ST_IDLE;
                    end else begin
                        r_Hold <= r_Hold - HOLD_W'(1);
                    end
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    assign o_Ready  = r_Ready;
    assign o_Digits = r_Digits;
    assign o_Blank  = r_Blank;
    assign o_Ovf    = r_Ovf;
    assign o_Done   = r_Done;

endmodule

// File: tb/tb_display_update_ctrl.sv
module tb_display_update_ctrl;
    localparam int NUM_W  = 16;
    localparam int DIGITS = 4;
    localparam int RC     = 8;
    localparam int PERIOD = NUM_W + 2 + RC;

    typedef struct {
        logic [4*DIGITS-1:0] d;
        logic [DIGITS-1:0]   b;
        logic                o;
        int                  acc;
    } exp_t;

    logic                i_Clk = 1'b0;
    logic                i_Rst = 1'b1;
    logic [NUM_W-1:0]    i_Num = '0;
    logic                i_Valid = 1'b0;
    logic                o_Ready;
    logic [4*DIGITS-1:0] o_Digits;
    logic [DIGITS-1:0]   o_Blank;
    logic                o_Ovf;
    logic                o_Done;

    display_update_ctrl #(.NUM_W(NUM_W), .DIGITS(DIGITS), .REFRESH_CYC(RC)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Num(i_Num), .i_Valid(i_Valid),
        .o_Ready(o_Ready), .o_Digits(o_Digits), .o_Blank(o_Blank),
        .o_Ovf(o_Ovf), .o_Done(o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   acc_cnt = 0;
    int   acc_last = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // Reference: decimal digits by division, saturate above 10^DIGITS-1.
    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        e.acc = acc;
        e.d = '0;
        e.b = '0;
        e.o = (v > pow10(DIGITS) - 1);
        for (int k = 0; k < DIGITS; k++) begin
            if (e.o) e.d[4*k +: 4] = 4'h9;
            else     e.d[4*k +: 4] = 4'((v / pow10(k)) % 10);
            e.b[k] = !e.o && (k >= 1) && (v < pow10(k));
        end
        return e;
    endfunction

    // Accept detector: scoreboard push on every handshake.
    always @(posedge i_Clk) begin
        if (!i_Rst && i_Valid && o_Ready) begin
            sb.push_back(model(int'(i_Num), cyc));
            acc_last = cyc;
            acc_cnt++;
        end
        cyc++;
    end

    // Monitor
    always @(negedge i_Clk) begin
        exp_t e;
        if (i_Rst) begin
            prev_done = 1'b0;
        end else begin
            if (o_Done) begin
                checks++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_width: o_Done high two cycles in a row at cyc %0d", cyc);
                end
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_done: o_Done with nothing pending at cyc %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (o_Digits !== e.d) begin
                        fails++;
                        $display("FAIL digits: got %h expected %h", o_Digits, e.d);
                    end
                    checks++;
                    if (o_Blank !== e.b) begin
                        fails++;
                        $display("FAIL blank: got %b expected %b", o_Blank, e.b);
                    end
                    checks++;
                    if (o_Ovf !== e.o) begin
                        fails++;
                        $display("FAIL ovf: got %b expected %b", o_Ovf, e.o);
                    end
                    checks++;
                    if (cyc - e.acc - 1 != NUM_W + 1) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.acc - 1, NUM_W + 1);
                    end
                end
            end
            prev_done = o_Done;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present v until accepted; afterwards scramble i_Num to prove only the
    // captured value is used.
    task automatic send(input int v, output int a);
        int n0;
        bit ok;
        n0 = acc_cnt;
        ok = 1'b0;
        i_Num = NUM_W'(v);
        i_Valid = 1'b1;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge i_Clk);
            if (acc_cnt != n0) begin ok = 1'b1; break; end
        end
        a = acc_last;
        i_Valid = 1'b0;
        i_Num = NUM_W'($urandom);
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout: value %0d not accepted", v);
        end
    endtask

    initial begin
        int a0, a1, v;
        // Reset state
        repeat (3) @(negedge i_Clk);
        check("rst_ready", 32'(o_Ready), 32'd0);
        check("rst_digits", 32'(o_Digits), 32'h0000);
        check("rst_blank", 32'(o_Blank), 32'b1110);
        check("rst_ovf", 32'(o_Ovf), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        i_Rst = 1'b0;
        @(negedge i_Clk);
        check("ready_after_rst", 32'(o_Ready), 32'd1);

        // Directed values, then a valid-held pair to measure the update rate
        send(1234, a0);
        send(7, a0);
        send(0, a1);
        check("accept_spacing", 32'(a1 - a0), 32'(PERIOD));
        send(50, a0);
        send(10000, a0);
        send(65535, a0);
        send(9999, a0);
        send(1000, a0);
        send(999, a0);

        // Reset in the middle of SHIFT: no done, outputs cleared
        send(4321, a0);
        repeat (4) @(negedge i_Clk);
        i_Rst = 1'b1;
        sb.delete();
        @(negedge i_Clk);
        check("midrst_digits", 32'(o_Digits), 32'h0000);
        check("midrst_blank", 32'(o_Blank), 32'b1110);
        check("midrst_ovf", 32'(o_Ovf), 32'd0);
        check("midrst_ready", 32'(o_Ready), 32'd0);
        i_Rst = 1'b0;
        send(42, a0);

        // Random sweep, biased half the time toward the saturation boundary
        for (int i = 0; i < 40; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(9000, 11000));
            send(v, a1);
            check("spacing_min", 32'(a1 - a0 >= PERIOD), 32'd1);
            a0 = a1;
        end

        // Drain
        for (int i = 0; i < 2 * PERIOD && sb.size() != 0; i++) @(negedge i_Clk);
        repeat (PERIOD) @(negedge i_Clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
